// File: rtl/rv_core_pkg.sv
// Shared core definitions: default register-file geometry, the address type,
// and the helper that decides whether an address names a writable register.
package rv_core_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

  // True for x1..x(nregs-1); x0 and addresses past the file are never storage.
  function automatic logic addr_ok(input int unsigned a, input int unsigned nregs);
    return (a != 0) && (a < nregs);
  endfunction

endpackage

// File: rtl/rv_scoreboard.sv
// Per-register pending-write scoreboard: issue sets a bit, writeback clears it
// (issue wins), plus the busy, WAW and sticky writeback-error indications.
module rv_scoreboard
  import rv_core_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int BYPASS = 1,
  parameter int AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs1_addr_i,
  input  logic [AW-1:0]    rs2_addr_i,
  input  logic             iss_valid_i,
  input  logic [AW-1:0]    iss_rd_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic             rs1_busy_o,
  output logic             rs2_busy_o,
  output logic             iss_waw_o,
  output logic [NREGS-1:0] busy_vec_o,
  output logic             wb_err_o
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic             err_q, err_d;
  logic             wr_ok;

  assign wr_ok = wr_en_i && addr_ok(32'(rd_addr_i), NREGS);

  always_comb begin
    pending_d = pending_q;
    for (int r = 1; r < NREGS; r++) begin
      if (iss_valid_i && (iss_rd_i == AW'(r))) begin
        pending_d[r] = 1'b1;
      end else if (wr_en_i && (rd_addr_i == AW'(r))) begin
        pending_d[r] = 1'b0;
      end
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    err_d = err_q;
    if (wr_ok && !pending_q[rd_addr_i]) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  // A same-cycle writeback hides the bit from readers only when it is forwarded.
  always_comb begin
    rs1_busy_o = 1'b0;
    if (addr_ok(32'(rs1_addr_i), NREGS)) begin
      rs1_busy_o = pending_q[rs1_addr_i] &&
                   !((BYPASS != 0) && wr_en_i && (rd_addr_i == rs1_addr_i));
    end
  end

  always_comb begin
    rs2_busy_o = 1'b0;
    if (addr_ok(32'(rs2_addr_i), NREGS)) begin
      rs2_busy_o = pending_q[rs2_addr_i] &&
                   !((BYPASS != 0) && wr_en_i && (rd_addr_i == rs2_addr_i));
    end
  end

  always_comb begin
    iss_waw_o = 1'b0;
    if (iss_valid_i && addr_ok(32'(iss_rd_i), NREGS)) begin
      iss_waw_o = pending_q[iss_rd_i] && !(wr_en_i && (rd_addr_i == iss_rd_i));
    end
  end

  assign busy_vec_o = pending_q;
  assign wb_err_o   = err_q;

endmodule

// File: rtl/rv_reg_file_sb.sv
// Pipelined-core register file: two combinational read ports with optional
// writeback forwarding, one writeback port, and a pending-write scoreboard.
module rv_reg_file_sb
  import rv_core_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int BYPASS = 1,
  localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs1_addr_i,
  input  logic [AW-1:0]    rs2_addr_i,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic             rs1_busy_o,
  output logic             rs2_busy_o,
  input  logic             iss_valid_i,
  input  logic [AW-1:0]    iss_rd_i,
  output logic             iss_waw_o,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  input  logic [XLEN-1:0]  wr_data_i,
  output logic [NREGS-1:0] busy_vec_o,
  output logic             wb_err_o
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_ok;

  assign wr_ok = wr_en_i && addr_ok(32'(rd_addr_i), NREGS);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[rd_addr_i] <= wr_data_i;
    end
  end

  // Out-of-range and x0 reads return zero before any forwarding is considered.
  always_comb begin
    rs1_data_o = '0;
    if (addr_ok(32'(rs1_addr_i), NREGS)) begin
      rs1_data_o = regs_q[rs1_addr_i];
      if ((BYPASS != 0) && wr_en_i && (rd_addr_i == rs1_addr_i)) begin
        rs1_data_o = wr_data_i;
      end
    end
  end

  always_comb begin
    rs2_data_o = '0;
    if (addr_ok(32'(rs2_addr_i), NREGS)) begin
      rs2_data_o = regs_q[rs2_addr_i];
      if ((BYPASS != 0) && wr_en_i && (rd_addr_i == rs2_addr_i)) begin
        rs2_data_o = wr_data_i;
      end
    end
  end

  rv_scoreboard #(
    .NREGS  (NREGS),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .rs1_addr_i  (rs1_addr_i),
    .rs2_addr_i  (rs2_addr_i),
    .iss_valid_i (iss_valid_i),
    .iss_rd_i    (iss_rd_i),
    .wr_en_i     (wr_en_i),
    .rd_addr_i   (rd_addr_i),
    .rs1_busy_o  (rs1_busy_o),
    .rs2_busy_o  (rs2_busy_o),
    .iss_waw_o   (iss_waw_o),
    .busy_vec_o  (busy_vec_o),
    .wb_err_o    (wb_err_o)
  );

endmodule
